// File: rtl/encoder_4_2_rr_pkg.sv
// Shared widths, output-stage state type and a popcount helper for the
// round-robin 4:2 encoder.
package encoder_4_2_rr_pkg;

   localparam int unsigned IN_W   = 4;
   localparam int unsigned CODE_W = 2;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_e;

   function automatic logic is_multi(input logic [IN_W-1:0] vec);
      logic [2:0] cnt;
      cnt = 3'd0;
      for (int i = 0; i < int'(IN_W); i++) begin
         cnt = cnt + {2'b00, vec[i]};
      end
      return (cnt >= 3'd2);
   endfunction

endpackage

// File: rtl/encoder_4_2_rr_if.sv
// Request/result handshake bundle; master drives requests and consumes
// results, slave is the encoder.
interface encoder_4_2_rr_if;
   import encoder_4_2_rr_pkg::*;

   logic [IN_W-1:0]   code_in;
   logic              in_valid;
   logic              in_ready;
   logic [CODE_W-1:0] code_out;
   logic              out_valid;
   logic              out_ready;
   logic              out_multi;
   logic              zero_err;

   modport master (
      output code_in, in_valid, out_ready,
      input  in_ready, code_out, out_valid, out_multi, zero_err
   );

   modport slave (
      input  code_in, in_valid, out_ready,
      output in_ready, code_out, out_valid, out_multi, zero_err
   );

endinterface

// File: rtl/encoder_4_2_rr_rr_pick_4.sv
// Combinational round-robin pick: first set bit of code_i searching upward
// from ptr_i with wrap-around.
module rr_pick_4
   import encoder_4_2_rr_pkg::*;
(
   input  logic [IN_W-1:0]   code_i,
   input  logic [CODE_W-1:0] ptr_i,
   output logic [CODE_W-1:0] index_o,
   output logic              any_o,
   output logic              multi_o
);

   logic [CODE_W-1:0] pos_s;

   // Walk the search order backwards so the earliest position overwrites later ones.
   always_comb begin
      index_o = {CODE_W{1'b0}};
      pos_s   = {CODE_W{1'b0}};
      for (int k = int'(IN_W) - 1; k >= 0; k--) begin
         pos_s   = ptr_i + CODE_W'(k);
         index_o = code_i[pos_s] ? pos_s : index_o;
      end
   end

   assign any_o   = |code_i;
   assign multi_o = is_multi(code_i);

endmodule

// File: rtl/encoder_4_2_rr.sv
// Round-robin 4:2 priority encoder with a one-entry registered output stage
// and valid/ready handshake on both sides.
module encoder_4_2_rr
   import encoder_4_2_rr_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   encoder_4_2_rr_if.slave  bus
);

   state_e            state_q, state_d;
   logic [CODE_W-1:0] code_q,  code_d;
   logic              multi_q, multi_d;
   logic              zero_q,  zero_d;
   logic [CODE_W-1:0] ptr_q,   ptr_d;

   logic [CODE_W-1:0] pick_idx_s;
   logic              pick_any_s;
   logic              pick_multi_s;
   logic              in_ready_s;
   logic              xfer_s;
   logic              load_s;

   rr_pick_4 u_pick (
      .code_i  (bus.code_in),
      .ptr_i   (ptr_q),
      .index_o (pick_idx_s),
      .any_o   (pick_any_s),
      .multi_o (pick_multi_s)
   );

   assign in_ready_s = (state_q == EMPTY) || bus.out_ready;
   assign xfer_s     = bus.in_valid && in_ready_s;
   assign load_s     = xfer_s && pick_any_s;

   // Next-state: a nonzero transfer always loads; zero transfers only raise zero_err.
   always_comb begin
      code_d  = load_s ? pick_idx_s : code_q;
      multi_d = load_s ? pick_multi_s : multi_q;
      ptr_d   = load_s ? (pick_idx_s + CODE_W'(1'b1)) : ptr_q;
      zero_d  = xfer_s && !pick_any_s;
      case (state_q)
         EMPTY:   state_d = load_s ? FULL : EMPTY;
         FULL:    state_d = (load_s || !bus.out_ready) ? FULL : EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   // Output stage registers; reset discards any held result immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         code_q  <= {CODE_W{1'b0}};
         multi_q <= 1'b0;
         zero_q  <= 1'b0;
         ptr_q   <= {CODE_W{1'b0}};
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         multi_q <= multi_d;
         zero_q  <= zero_d;
         ptr_q   <= ptr_d;
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = (state_q == FULL);
   assign bus.code_out  = code_q;
   assign bus.out_multi = multi_q;
   assign bus.zero_err  = zero_q;

endmodule

// File: tb/tb_encoder_4_2_rr.sv
// Scoreboard bench for encoder_4_2_rr: directed scenarios followed by random
// traffic, checked against a queue-based behavioural model.
module tb_encoder_4_2_rr;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   encoder_4_2_rr_if bus();

   encoder_4_2_rr dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [1:0] code;
      logic       multi;
   } res_t;

   res_t exp_q[$];
   bit   m_full = 1'b0;
   int   m_ptr  = 0;
   bit   m_zero = 1'b0;
   int   tests  = 0;
   int   fails  = 0;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one result slot, round-robin pick from the pointer.
   int   mi;
   int   midx;
   bit   mrdy;
   bit   mnz;
   res_t mr;
   always @(posedge clk) begin
      if (rst_n) begin
         mrdy   = !m_full || bus.out_ready;
         m_zero = 1'b0;
         mnz    = 1'b0;
         if (bus.in_valid && mrdy) begin
            if (bus.code_in == 4'd0) begin
               m_zero = 1'b1;
            end else begin
               midx = -1;
               for (int k = 0; k < 4; k++) begin
                  mi = (m_ptr + k) % 4;
                  if (midx < 0 && bus.code_in[mi]) midx = mi;
               end
               mr.code  = 2'(midx);
               mr.multi = ($countones(bus.code_in) >= 2);
               exp_q.push_back(mr);
               m_ptr = (midx + 1) % 4;
               mnz   = 1'b1;
            end
         end
         if (mnz) m_full = 1'b1;
         else if (bus.out_ready) m_full = 1'b0;
      end
   end

   always @(negedge rst_n) begin
      exp_q.delete();
      m_full = 1'b0;
      m_ptr  = 0;
      m_zero = 1'b0;
   end

   // Monitor: mid-cycle compare of everything the DUT presents.
   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_out_valid", bus.out_valid, 0);
         check("rst_code_out", bus.code_out, 0);
         check("rst_out_multi", bus.out_multi, 0);
         check("rst_zero_err", bus.zero_err, 0);
      end else begin
         check("zero_err", bus.zero_err, m_zero);
         check("out_valid", bus.out_valid, m_full);
         check("in_ready", bus.in_ready, (!m_full || bus.out_ready));
         check("ptr", dut.ptr_q, m_ptr);
         if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_result", 1, 0);
            end else begin
               check("code_out", bus.code_out, exp_q[0].code);
               check("out_multi", bus.out_multi, exp_q[0].multi);
               if (bus.out_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic cyc(input bit v, input logic [3:0] c, input bit r);
      bus.in_valid  = v;
      bus.code_in   = c;
      bus.out_ready = r;
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      bus.in_valid  = 1'b0;
      bus.code_in   = 4'd0;
      bus.out_ready = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      check("reset_out_valid", bus.out_valid, 0);
      check("reset_code_out", bus.code_out, 0);
      check("reset_zero_err", bus.zero_err, 0);
      check("reset_ptr", dut.ptr_q, 0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      do_reset();

      // Back-to-back from ptr=0 with all bits requested.
      repeat (5) cyc(1'b1, 4'b1111, 1'b1);
      check("rr_last_code", bus.code_out, 0);
      check("rr_last_multi", bus.out_multi, 1);
      cyc(1'b0, 4'b0000, 1'b1);

      // Stall while FULL with code 1.
      cyc(1'b1, 4'b0010, 1'b1);
      for (int s = 0; s < 3; s++) begin
         bus.in_valid  = 1'b1;
         bus.code_in   = 4'b1000;
         bus.out_ready = 1'b0;
         #1;
         check("stall_in_ready", bus.in_ready, 0);
         check("stall_code_out", bus.code_out, 1);
         @(posedge clk);
         #2;
      end
      cyc(1'b1, 4'b1000, 1'b1);
      check("unstall_code_out", bus.code_out, 3);
      cyc(1'b0, 4'b0000, 1'b1);

      // Zero transfer while EMPTY.
      cyc(1'b1, 4'b0000, 1'b0);
      check("zero_pulse", bus.zero_err, 1);
      check("zero_valid", bus.out_valid, 0);
      cyc(1'b0, 4'b0000, 1'b0);
      check("zero_pulse_end", bus.zero_err, 0);

      // Single transfer from reset, then wrap search from ptr=3.
      do_reset();
      cyc(1'b1, 4'b0100, 1'b0);
      check("single_valid", bus.out_valid, 1);
      check("single_code", bus.code_out, 2);
      check("single_multi", bus.out_multi, 0);
      check("single_ptr", dut.ptr_q, 3);
      cyc(1'b1, 4'b0011, 1'b1);
      check("wrap_code", bus.code_out, 0);
      check("wrap_multi", bus.out_multi, 1);
      check("wrap_ptr", dut.ptr_q, 1);

      // Zero transfer while FULL and draining.
      cyc(1'b1, 4'b0000, 1'b1);
      check("zero_drain_valid", bus.out_valid, 0);
      check("zero_drain_err", bus.zero_err, 1);

      // Asynchronous reset mid-cycle while FULL.
      cyc(1'b1, 4'b1010, 1'b0);
      check("pre_rst_valid", bus.out_valid, 1);
      bus.in_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("async_valid", bus.out_valid, 0);
      check("async_code", bus.code_out, 0);
      check("async_multi", bus.out_multi, 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      check("post_rst_ptr", dut.ptr_q, 0);

      // Random traffic.
      repeat (500) begin
         cyc(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
             ($urandom_range(0, 9) < 7));
      end
      repeat (3) cyc(1'b0, 4'b0000, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/encoder_4_2_rr.md
ENCODER_4_2_RR -- requirements
Module: encoder_4_2_rr

Interface
REQ-001 The block SHALL expose: clk  input  1  rising-edge clock for all state.
REQ-002 The block SHALL expose: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 The block SHALL expose: code_in  input  4  request vector; multi-hot permitted.
REQ-004 The block SHALL expose: in_valid  input  1  code_in qualifier.
REQ-005 The block SHALL expose: in_ready  output  1  block can accept code_in this cycle.
REQ-006 The block SHALL expose: code_out  output  2  binary index of the selected request bit.
REQ-007 The block SHALL expose: out_valid  output  1  code_out and out_multi hold a result.
REQ-008 The block SHALL expose: out_ready  input  1  consumer takes the result this cycle.
REQ-009 The block SHALL expose: out_multi  output  1  accepted vector had more than one bit set.
REQ-010 The block SHALL expose: zero_err  output  1  one-cycle pulse; an all-zero vector was accepted.

Function
REQ-011 An input transfer SHALL occur on a rising clk edge where in_valid=1 and in_ready=1.
REQ-012 in_ready SHALL equal (!out_valid || out_ready), combinationally; no other input-to-output combinational path is permitted.
REQ-013 The output stage SHALL be a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-014 EMPTY->FULL SHALL occur on a transfer with code_in!=0; EMPTY SHALL otherwise persist.
REQ-015 FULL->EMPTY SHALL occur when out_ready=1 and no nonzero transfer occurs the same edge.
REQ-016 FULL with out_ready=1 and a simultaneous nonzero transfer SHALL stay FULL with the new result loaded (back-to-back, one result per cycle).
REQ-017 FULL with out_ready=0 SHALL hold code_out and out_multi unchanged.
REQ-018 Selection SHALL be round-robin: a 2-bit pointer ptr names the highest-priority bit; search order ptr, ptr+1, ptr+2, ptr+3 modulo 4; first set bit wins.
REQ-019 On each nonzero transfer, ptr SHALL become (selected index + 1) modulo 4 (wraps 3->0); ptr SHALL not change otherwise.
REQ-020 out_multi SHALL be registered with code_out: 1 iff popcount(code_in)>=2 at the transfer.
REQ-021 Latency: code_out/out_valid SHALL appear the cycle after the transfer edge (one register stage).
REQ-022 A transfer with code_in=0 SHALL be consumed, SHALL not change ptr or FSM state, and SHALL pulse zero_err high for exactly the following cycle.
REQ-023 A zero transfer coinciding with out_ready=1 in FULL SHALL drain to EMPTY per REQ-015.

Reset
REQ-024 While rst_n=0: FSM=EMPTY, out_valid=0, code_out=2'b00, out_multi=0, zero_err=0, ptr=2'b00.
REQ-025 Reset SHALL take effect immediately on rst_n falling, independent of clk, and discard any held result.
REQ-026 The first edge after rst_n rises SHALL behave as a normal cycle from the reset state.

Structure
REQ-027 A shared package SHALL hold: input width constant (4), code width constant (2), FSM state typedef {EMPTY, FULL}.
REQ-028 One sub-module rr_pick_4 (combinational: code_in, ptr -> index, any, multi) SHALL hold the selection logic; encoder_4_2_rr owns ptr, FSM and output registers.

Verification
REQ-029 After reset, single transfer code_in=4'b0100 -> next cycle out_valid=1, code_out=2, out_multi=0, ptr=3.
REQ-030 From ptr=0, hold code_in=4'b1111, in_valid=1, out_ready=1 for 5 cycles -> code_out 0,1,2,3,0 on consecutive cycles, out_multi=1 each, out_valid continuous.
REQ-031 FULL with code_out=1, out_ready=0 for 3 cycles, in_valid=1 code_in=4'b1000 -> in_ready=0, code_out stays 1; raise out_ready -> next cycle code_out=3.
REQ-032 EMPTY, transfer code_in=4'b0000 -> zero_err=1 for one cycle, out_valid stays 0, ptr unchanged.
REQ-033 ptr=3, transfer code_in=4'b0011 -> code_out=0 (wrap search), ptr=1.
REQ-034 FULL, assert rst_n=0 mid-cycle -> out_valid, code_out, out_multi drop to 0 before next clk edge; ptr=0 after release.
